// File: rtl/rv64g_l2_pkg.sv
//==============================================================================
// rv64g_l2_pkg -- shared opcodes, FSM states and directory entry layout
// Rev 1.0
//==============================================================================
`default_nettype none

package rv64g_l2_pkg;

  localparam int unsigned L2_CORES = 4;
  localparam int unsigned L2_CID_W = $clog2(L2_CORES);

  typedef enum logic [2:0] {
    OP_ACQ_B     = 3'd0,
    OP_ACQ_T     = 3'd1,
    OP_REL_CLEAN = 3'd2,
    OP_REL_DIRTY = 3'd3,
    OP_EVICT     = 3'd4
  } l2_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_PROBE  = 3'd2,
    ST_PWAIT  = 3'd3,
    ST_WRITE  = 3'd4,
    ST_RESP   = 3'd5
  } dir_state_e;

  typedef struct packed {
    logic                dirty;
    logic [L2_CID_W-1:0] owner_id;
    logic                owner_valid;
    logic [L2_CORES-1:0] sharers;
    logic                valid;
  } dir_entry_t;

  function automatic logic [L2_CORES-1:0] core_onehot(input logic [L2_CID_W-1:0] c);
    logic [L2_CORES-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv64g_l2_dir_next_state.sv
//==============================================================================
// rv64g_l2_dir_next_state -- combinational coherence transition for one entry
// Rev 1.0
//==============================================================================
`default_nettype none

module rv64g_l2_dir_next_state
  import rv64g_l2_pkg::*;
(
  input  logic [2:0]          op_i,
  input  logic [L2_CID_W-1:0] core_i,
  input  dir_entry_t          entry_i,
  output dir_entry_t          entry_o,
  output logic [L2_CORES-1:0] mask_o,
  output logic                to_n_o,
  output logic                write_o,
  output logic                grant_t_o,
  output logic                err_o,
  output logic                rel_dirty_o
);

  logic [L2_CORES-1:0] core_bit;
  logic [L2_CORES-1:0] owner_bit;
  logic                own_is_core;

  always_comb begin
    core_bit    = core_onehot(core_i);
    owner_bit   = entry_i.owner_valid ? core_onehot(entry_i.owner_id) : '0;
    own_is_core = entry_i.valid && entry_i.owner_valid && (entry_i.owner_id == core_i);

    entry_o     = '0;
    mask_o      = '0;
    to_n_o      = 1'b0;
    write_o     = 1'b0;
    grant_t_o   = 1'b0;
    err_o       = 1'b0;
    rel_dirty_o = 1'b0;

    case (op_i)
      OP_ACQ_B: begin
        if (!entry_i.valid) begin
          entry_o.valid   = 1'b1;
          entry_o.sharers = core_bit;
          write_o         = 1'b1;
        end else if (!entry_i.owner_valid) begin
          entry_o.valid   = 1'b1;
          entry_o.sharers = entry_i.sharers | core_bit;
          write_o         = 1'b1;
        end else if (own_is_core) begin
          grant_t_o = 1'b1;
        end else begin
          // Remote owner is downgraded to a sharer alongside the requester
          mask_o          = owner_bit;
          entry_o.valid   = 1'b1;
          entry_o.sharers = owner_bit | core_bit;
          write_o         = 1'b1;
        end
      end
      OP_ACQ_T: begin
        if (entry_i.valid) begin
          mask_o = (entry_i.sharers | owner_bit) & ~core_bit;
        end
        to_n_o              = 1'b1;
        entry_o.valid       = 1'b1;
        entry_o.owner_valid = 1'b1;
        entry_o.owner_id    = core_i;
        entry_o.dirty       = 1'b1;
        write_o             = 1'b1;
        grant_t_o           = 1'b1;
      end
      OP_REL_CLEAN, OP_REL_DIRTY: begin
        rel_dirty_o = (op_i == OP_REL_DIRTY);
        if (own_is_core) begin
          entry_o.valid = 1'b1;
          write_o       = 1'b1;
        end else if (entry_i.valid && |(entry_i.sharers & core_bit)) begin
          entry_o         = entry_i;
          entry_o.sharers = entry_i.sharers & ~core_bit;
          write_o         = 1'b1;
        end else if (entry_i.valid) begin
          entry_o = entry_i;
          write_o = 1'b1;
          err_o   = 1'b1;
        end else begin
          err_o = 1'b1;
        end
      end
      OP_EVICT: begin
        if (entry_i.valid) begin
          mask_o = (entry_i.sharers | owner_bit) & ~core_bit;
        end
        to_n_o  = 1'b1;
        write_o = 1'b1;
      end
      default: begin
        err_o = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rv64g_l2_dir_ctrl.sv
//==============================================================================
// rv64g_l2_dir_ctrl -- L2 directory read-modify-write engine, one request in flight
// Rev 1.0 | optional: RV64G_L2_DIR_CTRL_STATS_EN adds stat_* counters
//==============================================================================
`default_nettype none

module rv64g_l2_dir_ctrl
  import rv64g_l2_pkg::*;
#(
  parameter  int unsigned SETS  = 256,
  parameter  int unsigned WAYS  = 16,
  parameter  int unsigned CORES = L2_CORES,
  localparam int unsigned SET_W = $clog2(SETS),
  localparam int unsigned WAY_W = $clog2(WAYS),
  localparam int unsigned CID_W = $clog2(CORES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [2:0]             req_op_i,
  input  logic [SET_W-1:0]       req_set_i,
  input  logic [WAY_W-1:0]       req_way_i,
  input  logic [CID_W-1:0]       req_core_i,
  output logic [SET_W-1:0]       dir_rd_set_o,
  input  logic [WAYS-1:0]        dir_rd_valid_i,
  input  logic [WAYS*CORES-1:0]  dir_rd_sharers_i,
  input  logic [WAYS-1:0]        dir_rd_owner_valid_i,
  input  logic [WAYS*CID_W-1:0]  dir_rd_owner_id_i,
  input  logic [WAYS-1:0]        dir_rd_dirty_i,
  output logic                   dir_we_o,
  output logic [SET_W-1:0]       dir_wr_set_o,
  output logic [WAY_W-1:0]       dir_wr_way_o,
  output logic                   dir_wr_valid_o,
  output logic [CORES-1:0]       dir_wr_sharers_o,
  output logic                   dir_wr_owner_valid_o,
  output logic [CID_W-1:0]       dir_wr_owner_id_o,
  output logic                   dir_wr_dirty_o,
  output logic                   probe_valid_o,
  input  logic                   probe_ready_i,
  output logic [CORES-1:0]       probe_mask_o,
  output logic                   probe_to_n_o,
  input  logic                   probe_done_i,
  input  logic                   probe_dirty_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic                   resp_grant_t_o,
  output logic                   resp_dirty_o,
  output logic                   resp_err_o
`ifdef RV64G_L2_DIR_CTRL_STATS_EN
  ,
  output logic [31:0]            stat_acq_o,
  output logic [31:0]            stat_probe_o,
  output logic [31:0]            stat_evict_o
`endif
);

  dir_state_e       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [WAY_W-1:0] way_q, way_d;
  logic [CID_W-1:0] core_q, core_d;
  dir_entry_t       entry_q, entry_d;
  logic [CORES-1:0] mask_q, mask_d;
  logic             to_n_q, to_n_d;
  logic             grant_q, grant_d;
  logic             err_q, err_d;
  logic             rdirty_q, rdirty_d;
  logic             pdirty_en_q, pdirty_en_d;

  dir_entry_t          rd_entry;
  dir_entry_t          ns_entry;
  logic [L2_CORES-1:0] ns_mask;
  logic                ns_to_n, ns_write, ns_grant, ns_err, ns_rel_dirty;

  always_comb begin
    rd_entry             = '0;
    rd_entry.valid       = dir_rd_valid_i[way_q];
    rd_entry.sharers     = dir_rd_sharers_i[way_q*CORES +: CORES];
    rd_entry.owner_valid = dir_rd_owner_valid_i[way_q];
    rd_entry.owner_id    = dir_rd_owner_id_i[way_q*CID_W +: CID_W];
    rd_entry.dirty       = dir_rd_dirty_i[way_q];
  end

  rv64g_l2_dir_next_state u_next (
    .op_i        (op_q),
    .core_i      (core_q),
    .entry_i     (rd_entry),
    .entry_o     (ns_entry),
    .mask_o      (ns_mask),
    .to_n_o      (ns_to_n),
    .write_o     (ns_write),
    .grant_t_o   (ns_grant),
    .err_o       (ns_err),
    .rel_dirty_o (ns_rel_dirty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      set_q       <= '0;
      way_q       <= '0;
      core_q      <= '0;
      entry_q     <= '0;
      mask_q      <= '0;
      to_n_q      <= 1'b0;
      grant_q     <= 1'b0;
      err_q       <= 1'b0;
      rdirty_q    <= 1'b0;
      pdirty_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      set_q       <= set_d;
      way_q       <= way_d;
      core_q      <= core_d;
      entry_q     <= entry_d;
      mask_q      <= mask_d;
      to_n_q      <= to_n_d;
      grant_q     <= grant_d;
      err_q       <= err_d;
      rdirty_q    <= rdirty_d;
      pdirty_en_q <= pdirty_en_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    set_d       = set_q;
    way_d       = way_q;
    core_d      = core_q;
    entry_d     = entry_q;
    mask_d      = mask_q;
    to_n_d      = to_n_q;
    grant_d     = grant_q;
    err_d       = err_q;
    rdirty_d    = rdirty_q;
    pdirty_en_d = pdirty_en_q;

    req_ready_o          = 1'b0;
    dir_rd_set_o         = '0;
    dir_we_o             = 1'b0;
    dir_wr_set_o         = '0;
    dir_wr_way_o         = '0;
    dir_wr_valid_o       = 1'b0;
    dir_wr_sharers_o     = '0;
    dir_wr_owner_valid_o = 1'b0;
    dir_wr_owner_id_o    = '0;
    dir_wr_dirty_o       = 1'b0;
    probe_valid_o        = 1'b0;
    probe_mask_o         = '0;
    probe_to_n_o         = 1'b0;
    resp_valid_o         = 1'b0;
    resp_grant_t_o       = 1'b0;
    resp_dirty_o         = 1'b0;
    resp_err_o           = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Ready drops immediately with reset so every output reads 0 while held
        req_ready_o = rst_n;
        if (req_valid_i) begin
          op_d    = req_op_i;
          set_d   = req_set_i;
          way_d   = req_way_i;
          core_d  = req_core_i;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        dir_rd_set_o = set_q;
        entry_d      = ns_entry;
        mask_d       = ns_mask;
        to_n_d       = ns_to_n;
        grant_d      = ns_grant;
        err_d        = ns_err;
        rdirty_d     = ns_rel_dirty;
        // Evict only reports probe data as dirty when the line was already dirty
        pdirty_en_d  = (op_q != OP_EVICT) || rd_entry.dirty;
        if (ns_mask != '0)  state_d = ST_PROBE;
        else if (ns_write)  state_d = ST_WRITE;
        else                state_d = ST_RESP;
      end
      ST_PROBE: begin
        probe_valid_o = 1'b1;
        probe_mask_o  = mask_q;
        probe_to_n_o  = to_n_q;
        if (probe_ready_i) state_d = ST_PWAIT;
      end
      ST_PWAIT: begin
        if (probe_done_i) begin
          rdirty_d = rdirty_q | (probe_dirty_i & pdirty_en_q);
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        dir_we_o             = 1'b1;
        dir_wr_set_o         = set_q;
        dir_wr_way_o         = way_q;
        dir_wr_valid_o       = entry_q.valid;
        dir_wr_sharers_o     = entry_q.sharers;
        dir_wr_owner_valid_o = entry_q.owner_valid;
        dir_wr_owner_id_o    = entry_q.owner_id;
        dir_wr_dirty_o       = entry_q.dirty;
        state_d              = ST_RESP;
      end
      ST_RESP: begin
        resp_valid_o   = 1'b1;
        resp_grant_t_o = grant_q;
        resp_dirty_o   = rdirty_q;
        resp_err_o     = err_q;
        if (resp_ready_i) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef RV64G_L2_DIR_CTRL_STATS_EN
  logic [31:0] stat_acq_q, stat_probe_q, stat_evict_q;
  logic        req_fire;

  assign req_fire = req_valid_i && req_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_acq_q   <= '0;
      stat_probe_q <= '0;
      stat_evict_q <= '0;
    end else begin
      if (req_fire && ((req_op_i == OP_ACQ_B) || (req_op_i == OP_ACQ_T)))
        stat_acq_q <= stat_acq_q + 32'd1;
      if (probe_valid_o && probe_ready_i)
        stat_probe_q <= stat_probe_q + 32'd1;
      if (req_fire && (req_op_i == OP_EVICT))
        stat_evict_q <= stat_evict_q + 32'd1;
    end
  end

  assign stat_acq_o   = stat_acq_q;
  assign stat_probe_o = stat_probe_q;
  assign stat_evict_o = stat_evict_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv64g_l2_dir_ctrl.sv
//==============================================================================
// tb_rv64g_l2_dir_ctrl -- directed self-checking bench for the directory engine
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_rv64g_l2_dir_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_op_i;
  logic [7:0]  req_set_i;
  logic [3:0]  req_way_i;
  logic [1:0]  req_core_i;
  logic [7:0]  dir_rd_set_o;
  logic [15:0] dir_valid;
  logic [63:0] dir_sharers;
  logic [15:0] dir_ov;
  logic [31:0] dir_oid;
  logic [15:0] dir_dirty;
  logic        dir_we_o;
  logic [7:0]  dir_wr_set_o;
  logic [3:0]  dir_wr_way_o;
  logic        dir_wr_valid_o;
  logic [3:0]  dir_wr_sharers_o;
  logic        dir_wr_owner_valid_o;
  logic [1:0]  dir_wr_owner_id_o;
  logic        dir_wr_dirty_o;
  logic        probe_valid_o;
  logic        probe_ready_i;
  logic [3:0]  probe_mask_o;
  logic        probe_to_n_o;
  logic        probe_done_i;
  logic        probe_dirty_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic        resp_grant_t_o;
  logic        resp_dirty_o;
  logic        resp_err_o;
`ifdef RV64G_L2_DIR_CTRL_STATS_EN
  logic [31:0] stat_acq_o, stat_probe_o, stat_evict_o;
`endif

  rv64g_l2_dir_ctrl dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .req_valid_i          (req_valid_i),
    .req_ready_o          (req_ready_o),
    .req_op_i             (req_op_i),
    .req_set_i            (req_set_i),
    .req_way_i            (req_way_i),
    .req_core_i           (req_core_i),
    .dir_rd_set_o         (dir_rd_set_o),
    .dir_rd_valid_i       (dir_valid),
    .dir_rd_sharers_i     (dir_sharers),
    .dir_rd_owner_valid_i (dir_ov),
    .dir_rd_owner_id_i    (dir_oid),
    .dir_rd_dirty_i       (dir_dirty),
    .dir_we_o             (dir_we_o),
    .dir_wr_set_o         (dir_wr_set_o),
    .dir_wr_way_o         (dir_wr_way_o),
    .dir_wr_valid_o       (dir_wr_valid_o),
    .dir_wr_sharers_o     (dir_wr_sharers_o),
    .dir_wr_owner_valid_o (dir_wr_owner_valid_o),
    .dir_wr_owner_id_o    (dir_wr_owner_id_o),
    .dir_wr_dirty_o       (dir_wr_dirty_o),
    .probe_valid_o        (probe_valid_o),
    .probe_ready_i        (probe_ready_i),
    .probe_mask_o         (probe_mask_o),
    .probe_to_n_o         (probe_to_n_o),
    .probe_done_i         (probe_done_i),
    .probe_dirty_i        (probe_dirty_i),
    .resp_valid_o         (resp_valid_o),
    .resp_ready_i         (resp_ready_i),
    .resp_grant_t_o       (resp_grant_t_o),
    .resp_dirty_o         (resp_dirty_o),
    .resp_err_o           (resp_err_o)
`ifdef RV64G_L2_DIR_CTRL_STATS_EN
    ,
    .stat_acq_o           (stat_acq_o),
    .stat_probe_o         (stat_probe_o),
    .stat_evict_o         (stat_evict_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int we_mon   = 0;

  always @(negedge clk) if (dir_we_o) we_mon++;

  // Observations of one transaction; written entry packed as {valid,sharers,ov,oid,dirty}
  logic [7:0] o_rd_set, o_wr_set;
  logic [3:0] o_wr_way, o_mask;
  logic [8:0] o_wr_word;
  logic       o_probe_seen, o_ton, o_unstable, o_busy_ready;
  logic       o_grant, o_rdirty, o_err;
  int         o_wr_cnt, o_wr_cyc, o_probe_cycles, o_resp_cyc;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_dir();
    dir_valid = '0; dir_sharers = '0; dir_ov = '0; dir_oid = '0; dir_dirty = '0;
  endtask

  task automatic set_way(input int w, input logic v, input logic [3:0] sh,
                         input logic ov, input logic [1:0] oid, input logic d);
    dir_valid[w]       = v;
    dir_sharers[w*4+:4] = sh;
    dir_ov[w]          = ov;
    dir_oid[w*2+:2]    = oid;
    dir_dirty[w]       = d;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge after the response handshake
  task automatic run_req(input logic [2:0] op, input logic [7:0] set, input logic [3:0] way,
                         input logic [1:0] core, input int pr_delay, input logic pdirty);
    int done_at;
    bit fin;
    done_at = -1; fin = 1'b0;
    o_rd_set = '0; o_wr_set = '0; o_wr_way = '0; o_mask = '0; o_wr_word = '0;
    o_probe_seen = 0; o_ton = 0; o_unstable = 0; o_busy_ready = 0;
    o_grant = 0; o_rdirty = 0; o_err = 0;
    o_wr_cnt = 0; o_wr_cyc = 0; o_probe_cycles = 0; o_resp_cyc = 0;
    req_op_i = op; req_set_i = set; req_way_i = way; req_core_i = core; req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
      if (cyc == 1) o_rd_set = dir_rd_set_o;
      if (req_ready_o) o_busy_ready = 1'b1;
      if (dir_we_o) begin
        o_wr_cnt++;
        o_wr_cyc  = cyc;
        o_wr_set  = dir_wr_set_o;
        o_wr_way  = dir_wr_way_o;
        o_wr_word = {dir_wr_valid_o, dir_wr_sharers_o, dir_wr_owner_valid_o,
                     dir_wr_owner_id_o, dir_wr_dirty_o};
      end
      probe_done_i  = (cyc == done_at);
      probe_dirty_i = (cyc == done_at) && pdirty;
      if (probe_valid_o) begin
        if (!o_probe_seen) begin
          o_mask = probe_mask_o;
          o_ton  = probe_to_n_o;
        end else if (probe_mask_o !== o_mask || probe_to_n_o !== o_ton) begin
          o_unstable = 1'b1;
        end
        o_probe_seen = 1'b1;
        o_probe_cycles++;
        probe_ready_i = (o_probe_cycles > pr_delay);
        if (probe_ready_i) done_at = cyc + 2;
      end else begin
        probe_ready_i = 1'b0;
      end
      if (resp_valid_o) begin
        o_resp_cyc   = cyc;
        o_grant      = resp_grant_t_o;
        o_rdirty     = resp_dirty_o;
        o_err        = resp_err_o;
        resp_ready_i = 1'b1;
        fin          = 1'b1;
      end
      @(negedge clk);
    end
    resp_ready_i = 1'b0; probe_ready_i = 1'b0; probe_done_i = 1'b0; probe_dirty_i = 1'b0;
    if (!fin) check_eq("resp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int we_snap;
    rst_n = 1'b0; req_valid_i = 0; req_op_i = 0; req_set_i = 0; req_way_i = 0; req_core_i = 0;
    probe_ready_i = 0; probe_done_i = 0; probe_dirty_i = 0; resp_ready_i = 0;
    clear_dir();
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_ready",   {31'd0, req_ready_o},   32'd0);
    check_eq("rst_we",      {31'd0, dir_we_o},      32'd0);
    check_eq("rst_probe",   {31'd0, probe_valid_o}, 32'd0);
    check_eq("rst_resp",    {31'd0, resp_valid_o},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_ready",  {31'd0, req_ready_o},   32'd1);

    // ACQ_B core1, invalid set 5 way 3
    run_req(3'd0, 8'd5, 4'd3, 2'd1, 0, 1'b0);
    check_eq("t1_rd_set",   {24'd0, o_rd_set},  32'd5);
    check_eq("t1_wr_cnt",   o_wr_cnt,           32'd1);
    check_eq("t1_wr_cyc",   o_wr_cyc,           32'd2);
    check_eq("t1_wr_addr",  {20'd0, o_wr_set, o_wr_way}, {20'd0, 8'd5, 4'd3});
    check_eq("t1_wr_word",  {23'd0, o_wr_word}, {23'd0, 9'b1_0010_0_00_0});
    check_eq("t1_probe",    {31'd0, o_probe_seen}, 32'd0);
    check_eq("t1_resp_cyc", o_resp_cyc,         32'd3);
    check_eq("t1_flags",    {29'd0, o_grant, o_rdirty, o_err}, 32'd0);
    check_eq("t1_busy_rdy", {31'd0, o_busy_ready}, 32'd0);
    check_eq("t1_idle_rdy", {31'd0, req_ready_o},  32'd1);

    // ACQ_T core0 with sharers 1011
    clear_dir();
    set_way(7, 1'b1, 4'b1011, 1'b0, 2'd0, 1'b0);
    run_req(3'd1, 8'd9, 4'd7, 2'd0, 0, 1'b0);
    check_eq("t2_mask",     {28'd0, o_mask},    32'b1010);
    check_eq("t2_to_n",     {31'd0, o_ton},     32'd1);
    check_eq("t2_wr_word",  {23'd0, o_wr_word}, {23'd0, 9'b1_0000_1_00_1});
    check_eq("t2_wr_cnt",   o_wr_cnt,           32'd1);
    check_eq("t2_flags",    {29'd0, o_grant, o_rdirty, o_err}, 32'b100);
    check_eq("t2_resp_cyc", o_resp_cyc,         32'd6);

    // Owner 2 dirty, ACQ_B core3, probe returns dirty data
    clear_dir();
    set_way(2, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1);
    run_req(3'd0, 8'd20, 4'd2, 2'd3, 0, 1'b1);
    check_eq("t3_mask",     {28'd0, o_mask},    32'b0100);
    check_eq("t3_to_n",     {31'd0, o_ton},     32'd0);
    check_eq("t3_wr_word",  {23'd0, o_wr_word}, {23'd0, 9'b1_1100_0_00_0});
    check_eq("t3_flags",    {29'd0, o_grant, o_rdirty, o_err}, 32'b010);

    // Owner 1, REL_DIRTY core1 then REL_CLEAN core2 on the released entry
    clear_dir();
    set_way(4, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1);
    run_req(3'd3, 8'd33, 4'd4, 2'd1, 0, 1'b0);
    check_eq("t4_probe",    {31'd0, o_probe_seen}, 32'd0);
    check_eq("t4_wr_word",  {23'd0, o_wr_word}, {23'd0, 9'b1_0000_0_00_0});
    check_eq("t4_flags",    {29'd0, o_grant, o_rdirty, o_err}, 32'b010);
    set_way(4, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
    run_req(3'd2, 8'd33, 4'd4, 2'd2, 0, 1'b0);
    check_eq("t4b_wr_cnt",  o_wr_cnt,           32'd1);
    check_eq("t4b_wr_word", {23'd0, o_wr_word}, {23'd0, 9'b1_0000_0_00_0});
    check_eq("t4b_flags",   {29'd0, o_grant, o_rdirty, o_err}, 32'b001);

    // ACQ_B by the current owner: grant T, no write
    clear_dir();
    set_way(5, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1);
    run_req(3'd0, 8'd40, 4'd5, 2'd3, 0, 1'b0);
    check_eq("t5_wr_cnt",   o_wr_cnt,           32'd0);
    check_eq("t5_flags",    {29'd0, o_grant, o_rdirty, o_err}, 32'b100);

    // Illegal opcode
    run_req(3'd6, 8'd41, 4'd1, 2'd0, 0, 1'b0);
    check_eq("t6_wr_cnt",   o_wr_cnt,           32'd0);
    check_eq("t6_probe",    {31'd0, o_probe_seen}, 32'd0);
    check_eq("t6_err",      {31'd0, o_err},     32'd1);
    check_eq("t6_resp_cyc", o_resp_cyc,         32'd2);

    // EVICT with sharers 0110, probe_ready delayed 3 cycles
    clear_dir();
    set_way(6, 1'b1, 4'b0110, 1'b0, 2'd0, 1'b0);
    run_req(3'd4, 8'd77, 4'd6, 2'd0, 3, 1'b0);
    check_eq("t7_mask",     {28'd0, o_mask},    32'b0110);
    check_eq("t7_to_n",     {31'd0, o_ton},     32'd1);
    check_eq("t7_stable",   {31'd0, o_unstable}, 32'd0);
    check_eq("t7_probe_cy", o_probe_cycles,     32'd4);
    check_eq("t7_wr_word",  {23'd0, o_wr_word}, 32'd0);
    check_eq("t7_wr_addr",  {20'd0, o_wr_set, o_wr_way}, {20'd0, 8'd77, 4'd6});
    check_eq("t7_busy_rdy", {31'd0, o_busy_ready}, 32'd0);
    check_eq("t7_resp_cyc", o_resp_cyc,         32'd9);

    // Reset asserted while waiting for probe acks
    we_snap = we_mon;
    req_op_i = 3'd4; req_set_i = 8'd3; req_way_i = 4'd6; req_core_i = 2'd0; req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    check_eq("t8_probe_vld", {31'd0, probe_valid_o}, 32'd1);
    probe_ready_i = 1'b1;
    @(negedge clk);
    probe_ready_i = 1'b0;
    check_eq("t8_pwait",    {31'd0, probe_valid_o}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("t8_outs", {26'd0, req_ready_o, dir_we_o, probe_valid_o, resp_valid_o,
                         |probe_mask_o, |dir_wr_sharers_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t8_no_write", we_mon - we_snap,   32'd0);
    check_eq("t8_idle_rdy", {31'd0, req_ready_o}, 32'd1);
    check_eq("t8_resp",     {31'd0, resp_valid_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
